instruction_prefetch_unit: RTL and testbench

//  Fetches 16-bit instructions from the byte-wide memory and buffers them for the control unit.
//  - Reads two bytes per instruction: low byte first, then high byte (low byte -> IR[7:0], high byte -> IR[15:8]).
//  - Holds up to DEPTH decoded-ready instructions in a small queue.
//  - Sits directly upstream of the control unit. This frees the control unit's sequence counter from the two fetch steps.

---
 rtl/instruction_prefetch_unit.sv | 122 ++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_unit.sv
// instruction_prefetch_unit
// Fetches 16-bit instructions as two byte reads (low byte, then high byte)
// from a byte-wide memory. Completed instructions wait in a small FIFO, tagged
// with the address of their low byte, until the control unit consumes them.
module instruction_prefetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Mem_Grant,
  input  logic [7:0]        Mem_Data,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              PC_Load,
  input  logic [ADDR_W-1:0] PC_LoadVal,
  output logic              IR_Valid,
  input  logic              IR_Ready,
  output logic [15:0]       IR_Out,
  output logic [ADDR_W-1:0] IR_PC,
  output logic [ADDR_W-1:0] PC_Out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] FETCH_LO = 1'b0;
  localparam logic [0:0] FETCH_HI = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        lo_reg;
  logic [ADDR_W-1:0] tag_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [15:0]       data_reg [DEPTH];
  logic [ADDR_W-1:0] pc_tag_reg [DEPTH];

  logic queue_valid;
  logic not_full;
  logic pop;
  logic access;
  logic push;

  // Handshake decode. A redirect blocks both the pop and the memory access, and
  // nothing is fetched while reset is held, so the chip select stays inactive.
  always_comb begin
    queue_valid = (count_reg != '0);
    not_full    = (count_reg < CNT_W'(DEPTH));
    pop         = queue_valid & IR_Ready & ~PC_Load;
    access      = Reset & ~PC_Load & Mem_Grant & (not_full | pop);
    push        = access & (state_reg == FETCH_HI);
  end

  // Fetch FSM, PC, low-byte latch and queue pointers/occupancy.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= FETCH_LO;
      pc_reg    <= PC_RESET;
      lo_reg    <= '0;
      tag_reg   <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (PC_Load) begin
      // Redirect flushes the queue and any half-fetched instruction.
      state_reg <= FETCH_LO;
      pc_reg    <= PC_LoadVal;
      lo_reg    <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (access) begin
        pc_reg <= pc_reg + ADDR_W'(1);
        if (state_reg == FETCH_LO) begin
          lo_reg    <= Mem_Data;
          tag_reg   <= pc_reg;
          state_reg <= FETCH_HI;
        end else begin
          state_reg <= FETCH_LO;
        end
      end
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // One storage slot per queue entry, written when the tail points at it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the completed instruction and its low-byte address.
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          data_reg[gi]   <= '0;
          pc_tag_reg[gi] <= '0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          data_reg[gi]   <= {Mem_Data, lo_reg};
          pc_tag_reg[gi] <= tag_reg;
        end
      end
    end
  endgenerate

  // Head and memory-port outputs, zeroed while the queue is empty.
  always_comb begin
    IR_Valid = queue_valid;
    IR_Out   = queue_valid ? data_reg[head_reg]   : 16'h0000;
    IR_PC    = queue_valid ? pc_tag_reg[head_reg] : '0;
    Mem_CS   = ~access;
    Mem_WR   = 1'b0;
    Mem_Addr = pc_reg;
    PC_Out   = pc_reg;
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed testbench for instruction_prefetch_unit: a byte memory model
// answers reads combinationally, and each scenario task checks outputs against
// hand-computed values.
module tb_instruction_prefetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Mem_Grant;
  logic [7:0]  Mem_Data;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [15:0] Mem_Addr;
  logic        PC_Load;
  logic [15:0] PC_LoadVal;
  logic        IR_Valid;
  logic        IR_Ready;
  logic [15:0] IR_Out;
  logic [15:0] IR_PC;
  logic [15:0] PC_Out;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  assign Mem_Data = mem[Mem_Addr];

  instruction_prefetch_unit #(
    .ADDR_W  (16),
    .DEPTH   (2),
    .PC_RESET(16'h0000)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Mem_Grant (Mem_Grant),
    .Mem_Data  (Mem_Data),
    .Mem_CS    (Mem_CS),
    .Mem_WR    (Mem_WR),
    .Mem_Addr  (Mem_Addr),
    .PC_Load   (PC_Load),
    .PC_LoadVal(PC_LoadVal),
    .IR_Valid  (IR_Valid),
    .IR_Ready  (IR_Ready),
    .IR_Out    (IR_Out),
    .IR_PC     (IR_PC),
    .PC_Out    (PC_Out)
  );

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Hold reset across an edge, then release it between edges.
  task automatic do_reset();
    Reset      = 1'b0;
    Mem_Grant  = 1'b0;
    PC_Load    = 1'b0;
    PC_LoadVal = 16'h0000;
    IR_Ready   = 1'b0;
    tick(1);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    Mem_Grant  = 1'b1;
    PC_Load    = 1'b0;
    PC_LoadVal = 16'h0000;
    IR_Ready   = 1'b0;
    tick(1);
    checks++; if (IR_Valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %0b want 0", IR_Valid); end
    checks++; if (IR_Out !== 16'h0000) begin errors++; $display("FAIL reset_ir_out got %h want 0000", IR_Out); end
    checks++; if (IR_PC !== 16'h0000) begin errors++; $display("FAIL reset_ir_pc got %h want 0000", IR_PC); end
    checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL reset_mem_cs got %0b want 1", Mem_CS); end
    checks++; if (Mem_WR !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %0b want 0", Mem_WR); end
    checks++; if (Mem_Addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", Mem_Addr); end
    checks++; if (PC_Out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out got %h want 0000", PC_Out); end
    $display("test_reset: outputs checked while reset held");
  endtask

  // First instruction after reset, then fill the queue and pop once.
  task automatic test_first_fetch_and_fill();
    do_reset();
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
    mem[16'h0004] = 8'hBC; mem[16'h0005] = 8'h9A;
    Mem_Grant = 1'b1;
    IR_Ready  = 1'b0;
    #1;
    checks++; if (Mem_CS !== 1'b0) begin errors++; $display("FAIL first_cs got %0b want 0", Mem_CS); end
    tick(1);
    checks++; if (IR_Valid !== 1'b0) begin errors++; $display("FAIL first_valid_edge1 got %0b want 0", IR_Valid); end
    checks++; if (PC_Out !== 16'h0001) begin errors++; $display("FAIL first_pc_edge1 got %h want 0001", PC_Out); end
    tick(1);
    checks++; if (IR_Valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", IR_Valid); end
    checks++; if (IR_Out !== 16'h1234) begin errors++; $display("FAIL first_ir_out got %h want 1234", IR_Out); end
    checks++; if (IR_PC !== 16'h0000) begin errors++; $display("FAIL first_ir_pc got %h want 0000", IR_PC); end
    checks++; if (PC_Out !== 16'h0002) begin errors++; $display("FAIL first_pc_out got %h want 0002", PC_Out); end
    $display("test_first_fetch: IR_Out=%h IR_PC=%h PC_Out=%h", IR_Out, IR_PC, PC_Out);
    tick(2);
    checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL full_cs got %0b want 1", Mem_CS); end
    checks++; if (PC_Out !== 16'h0004) begin errors++; $display("FAIL full_pc got %h want 0004", PC_Out); end
    tick(1);
    checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL full_cs_hold got %0b want 1", Mem_CS); end
    checks++; if (PC_Out !== 16'h0004) begin errors++; $display("FAIL full_pc_hold got %h want 0004", PC_Out); end
    checks++; if (IR_Out !== 16'h1234) begin errors++; $display("FAIL full_head got %h want 1234", IR_Out); end
    IR_Ready = 1'b1;
    #1;
    checks++; if (Mem_CS !== 1'b0) begin errors++; $display("FAIL pop_resume_cs got %0b want 0", Mem_CS); end
    checks++; if (Mem_Addr !== 16'h0004) begin errors++; $display("FAIL pop_resume_addr got %h want 0004", Mem_Addr); end
    tick(1);
    IR_Ready = 1'b0;
    #1;
    checks++; if (IR_Out !== 16'h5678) begin errors++; $display("FAIL pop_head got %h want 5678", IR_Out); end
    checks++; if (IR_PC !== 16'h0002) begin errors++; $display("FAIL pop_head_pc got %h want 0002", IR_PC); end
    checks++; if (PC_Out !== 16'h0005) begin errors++; $display("FAIL pop_pc got %h want 0005", PC_Out); end
    $display("test_queue_fill: head=%h at %h, PC_Out=%h", IR_Out, IR_PC, PC_Out);
  endtask

  // Grant withdrawn while waiting for the high byte.
  task automatic test_grant_stall();
    do_reset();
    mem[16'h0000] = 8'hAB; mem[16'h0001] = 8'hCD;
    Mem_Grant = 1'b1;
    tick(1);
    Mem_Grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL stall_cs[%0d] got %0b want 1", i, Mem_CS); end
      checks++; if (PC_Out !== 16'h0001) begin errors++; $display("FAIL stall_pc[%0d] got %h want 0001", i, PC_Out); end
      checks++; if (IR_Valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 0", i, IR_Valid); end
    end
    Mem_Grant = 1'b1;
    tick(1);
    checks++; if (IR_Out !== 16'hCDAB) begin errors++; $display("FAIL stall_ir_out got %h want CDAB", IR_Out); end
    checks++; if (IR_PC !== 16'h0000) begin errors++; $display("FAIL stall_ir_pc got %h want 0000", IR_PC); end
    checks++; if (PC_Out !== 16'h0002) begin errors++; $display("FAIL stall_pc_final got %h want 0002", PC_Out); end
    $display("test_grant_stall: IR_Out=%h PC_Out=%h", IR_Out, PC_Out);
  endtask

  // Redirect in FETCH_HI with one entry queued and a pop requested.
  task automatic test_pc_load();
    do_reset();
    mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22; mem[16'h0002] = 8'h33;
    mem[16'h0040] = 8'hEF; mem[16'h0041] = 8'hBE;
    Mem_Grant = 1'b1;
    tick(3);
    checks++; if (IR_Valid !== 1'b1 || PC_Out !== 16'h0003) begin errors++; $display("FAIL load_setup got valid=%0b pc=%h want valid=1 pc=0003", IR_Valid, PC_Out); end
    PC_Load    = 1'b1;
    PC_LoadVal = 16'h0040;
    IR_Ready   = 1'b1;
    #1;
    checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL load_cycle_cs got %0b want 1", Mem_CS); end
    tick(1);
    PC_Load  = 1'b0;
    IR_Ready = 1'b0;
    #1;
    checks++; if (IR_Valid !== 1'b0) begin errors++; $display("FAIL load_valid got %0b want 0", IR_Valid); end
    checks++; if (PC_Out !== 16'h0040) begin errors++; $display("FAIL load_pc got %h want 0040", PC_Out); end
    tick(2);
    checks++; if (IR_Valid !== 1'b1) begin errors++; $display("FAIL load_new_valid got %0b want 1", IR_Valid); end
    checks++; if (IR_PC !== 16'h0040) begin errors++; $display("FAIL load_new_pc got %h want 0040", IR_PC); end
    checks++; if (IR_Out !== 16'hBEEF) begin errors++; $display("FAIL load_new_ir got %h want BEEF", IR_Out); end
    $display("test_pc_load: IR_Out=%h IR_PC=%h", IR_Out, IR_PC);
  endtask

  // Instruction straddling the top of the address space.
  task automatic test_wrap();
    do_reset();
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
    Mem_Grant  = 1'b1;
    PC_Load    = 1'b1;
    PC_LoadVal = 16'hFFFF;
    tick(1);
    PC_Load = 1'b0;
    tick(2);
    checks++; if (IR_Out !== 16'h5678) begin errors++; $display("FAIL wrap_ir got %h want 5678", IR_Out); end
    checks++; if (IR_PC !== 16'hFFFF) begin errors++; $display("FAIL wrap_ir_pc got %h want FFFF", IR_PC); end
    checks++; if (PC_Out !== 16'h0001) begin errors++; $display("FAIL wrap_pc got %h want 0001", PC_Out); end
    $display("test_wrap: IR_Out=%h IR_PC=%h PC_Out=%h", IR_Out, IR_PC, PC_Out);
  endtask

  // Reset asserted between edges takes effect immediately.
  task automatic test_async_reset();
    do_reset();
    Mem_Grant = 1'b1;
    tick(4);
    checks++; if (IR_Valid !== 1'b1 || PC_Out !== 16'h0004) begin errors++; $display("FAIL areset_setup got valid=%0b pc=%h want valid=1 pc=0004", IR_Valid, PC_Out); end
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (IR_Valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", IR_Valid); end
    checks++; if (Mem_CS !== 1'b1) begin errors++; $display("FAIL areset_cs got %0b want 1", Mem_CS); end
    checks++; if (PC_Out !== 16'h0000) begin errors++; $display("FAIL areset_pc got %h want 0000", PC_Out); end
    checks++; if (IR_Out !== 16'h0000) begin errors++; $display("FAIL areset_ir got %h want 0000", IR_Out); end
    $display("test_async_reset: IR_Valid=%0b Mem_CS=%0b PC_Out=%h", IR_Valid, Mem_CS, PC_Out);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    Reset      = 1'b0;
    Mem_Grant  = 1'b0;
    PC_Load    = 1'b0;
    PC_LoadVal = 16'h0000;
    IR_Ready   = 1'b0;
    test_reset();
    test_first_fetch_and_fill();
    test_grant_stall();
    test_pc_load();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
